// File: rtl/parse_sign_if.sv
// Bus bundle for parse_sign: the packed signature and challenge list going in,
// and the scattered per-slot verification fields coming out.
interface parse_sign_if;
    // Level handshake: the master raises parse_start and holds it until it sees
    // parse_end. parse_end then stays high while parse_start stays high, and it
    // drops on the first edge that samples parse_start low. parse_err is only
    // meaningful while parse_end is high.
    logic             parse_start;
    logic [19:0]      lc;
    logic [19583:0]   sigma;
    logic [255:0]     h_t_o;
    logic [255:0]     salt_o;
    logic [127:0]     seed_triangle_o;
    logic [7:0]       lc_mask_o;
    logic [1023:0]    seed_star_o;
    logic [2047:0]    Cv_o;
    logic [15359:0]   seed_o;
    logic [1023:0]    masked_key_o;
    logic [4095:0]    msgs_o;
    logic [2047:0]    C_o;
    logic [4095:0]    seed_lambda_o;
    logic [8191:0]    aux_triangle_o;
    logic             parse_end;
    logic             parse_err;
    logic [1:0]       state_dbg;

    modport master (
        output parse_start, lc, sigma,
        input  h_t_o, salt_o, seed_triangle_o, lc_mask_o, seed_star_o, Cv_o,
               seed_o, masked_key_o, msgs_o, C_o, seed_lambda_o, aux_triangle_o,
               parse_end, parse_err, state_dbg
    );

    modport slave (
        input  parse_start, lc, sigma,
        output h_t_o, salt_o, seed_triangle_o, lc_mask_o, seed_star_o, Cv_o,
               seed_o, masked_key_o, msgs_o, C_o, seed_lambda_o, aux_triangle_o,
               parse_end, parse_err, state_dbg
    );
endinterface

// File: rtl/parse_sign.sv
// Scatters a packed signature into 8-slot per-index arrays: challenged slots
// take the next Z payload, unchallenged slots take the next (iSeed, cv) pair.
module parse_sign (
    input  logic         clk,
    input  logic         reset,
    parse_sign_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      j;
    logic [2:0]      cnt_c;
    logic [2:0]      cnt_u;
    logic            err;
    logic [19:0]     lc_q;
    // Only the iSeed/cv/Z body is kept; h_t, salt and seed_triangle go straight out.
    logic [18943:0]  body_q;

    logic            chal;
    logic [2:0]      slot_idx;
    logic [4351:0]   z_sel;
    logic [127:0]    iseed_sel;
    logic [255:0]    cv_sel;

    always_comb begin
        chal      = (lc_q[19:15] == {2'b00, j}) || (lc_q[14:10] == {2'b00, j}) ||
                    (lc_q[9:5]   == {2'b00, j}) || (lc_q[4:0]   == {2'b00, j});
        slot_idx  = 3'd7 - j;
        z_sel     = '0;
        iseed_sel = '0;
        cv_sel    = '0;
        case (cnt_c[1:0])
            2'd0: z_sel = body_q[17407 -: 4352];
            2'd1: z_sel = body_q[13055 -: 4352];
            2'd2: z_sel = body_q[8703 -: 4352];
            default: z_sel = body_q[4351 -: 4352];
        endcase
        case (cnt_u[1:0])
            2'd0: begin iseed_sel = body_q[18943 -: 128]; cv_sel = body_q[18431 -: 256]; end
            2'd1: begin iseed_sel = body_q[18815 -: 128]; cv_sel = body_q[18175 -: 256]; end
            2'd2: begin iseed_sel = body_q[18687 -: 128]; cv_sel = body_q[17919 -: 256]; end
            default: begin iseed_sel = body_q[18559 -: 128]; cv_sel = body_q[17663 -: 256]; end
        endcase
    end

    assign bus.state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            j                    <= '0;
            cnt_c                <= '0;
            cnt_u                <= '0;
            err                  <= 1'b0;
            lc_q                 <= '0;
            body_q               <= '0;
            bus.h_t_o            <= '0;
            bus.salt_o           <= '0;
            bus.seed_triangle_o  <= '0;
            bus.lc_mask_o        <= '0;
            bus.seed_star_o      <= '0;
            bus.Cv_o             <= '0;
            bus.seed_o           <= '0;
            bus.masked_key_o     <= '0;
            bus.msgs_o           <= '0;
            bus.C_o              <= '0;
            bus.seed_lambda_o    <= '0;
            bus.aux_triangle_o   <= '0;
            bus.parse_end        <= 1'b0;
            bus.parse_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.parse_start && !bus.parse_end) begin
                        lc_q                 <= bus.lc;
                        body_q               <= bus.sigma[19071:128];
                        bus.h_t_o            <= bus.sigma[19583 -: 256];
                        bus.salt_o           <= bus.sigma[19327 -: 256];
                        bus.seed_triangle_o  <= bus.sigma[127:0];
                        bus.lc_mask_o        <= '0;
                        bus.seed_star_o      <= '0;
                        bus.Cv_o             <= '0;
                        bus.seed_o           <= '0;
                        bus.masked_key_o     <= '0;
                        bus.msgs_o           <= '0;
                        bus.C_o              <= '0;
                        bus.seed_lambda_o    <= '0;
                        bus.aux_triangle_o   <= '0;
                        j                    <= '0;
                        cnt_c                <= '0;
                        cnt_u                <= '0;
                        err                  <= 1'b0;
                        state                <= SCAN;
                    end
                end
                SCAN: begin
                    if (chal) begin
                        if (cnt_c != 3'd4) begin
                            bus.seed_o[1920*slot_idx +: 1920]        <= z_sel[4351 -: 1920];
                            bus.masked_key_o[128*slot_idx +: 128]    <= z_sel[2431 -: 128];
                            bus.msgs_o[512*slot_idx +: 512]          <= z_sel[2303 -: 512];
                            bus.C_o[256*slot_idx +: 256]             <= z_sel[1791 -: 256];
                            bus.seed_lambda_o[512*slot_idx +: 512]   <= z_sel[1535 -: 512];
                            bus.aux_triangle_o[1024*slot_idx +: 1024] <= z_sel[1023:0];
                            bus.lc_mask_o[j]                         <= 1'b1;
                            cnt_c                                    <= cnt_c + 3'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        if (cnt_u != 3'd4) begin
                            bus.seed_star_o[128*slot_idx +: 128] <= iseed_sel;
                            bus.Cv_o[256*slot_idx +: 256]        <= cv_sel;
                            cnt_u                                <= cnt_u + 3'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    j <= j + 3'd1;
                    if (j == 3'd7) state <= DONE;
                end
                DONE: begin
                    // A short challenge count means duplicate or out-of-range entries.
                    if (!bus.parse_end) begin
                        bus.parse_end <= 1'b1;
                        bus.parse_err <= err || (cnt_c != 3'd4);
                    end else if (!bus.parse_start) begin
                        bus.parse_end <= 1'b0;
                        bus.parse_err <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/parse_sign.md
Name: parse_sign

Overview:
- Verifier-side counterpart of the signature assembly stage.
- Takes a packed 19584-bit signature sigma and the challenge list lc (4 challenged party/round indices out of 8).
- Scans the 8 slots sequentially and scatters the signature fields back into 8-slot per-index arrays for the verification datapath.
  - Challenged slots receive their Z payload.
  - Unchallenged slots receive their (seed_star, Cv) pair.

Parameters:
- none; all geometry is fixed: 8 slots, 4 challenged, Z = 4352 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- parse_start  in  1  level request; held high until parse_end is seen.
- lc  in  20  four 5-bit challenge indices; lc[19:15]=LC0 … lc[4:0]=LC3.
- sigma  in  19584  packed, MSB first: h_t(256), salt(256), iSeed0..3(128 each), cv0..3(256 each), Z0..3(4352 each), seed_triangle(128).
- h_t_o  out  256  copy of the h_t field.
- salt_o  out  256  copy of the salt field.
- seed_triangle_o  out  128  copy of the seed_triangle field.
- lc_mask_o  out  8  bit j set when slot j is challenged.
- seed_star_o  out  8*128  slot j at bits [128*(8-j)-1 -: 128] (slot 0 in the MSBs); same slot ordering for every 8-slot output.
- Cv_o  out  8*256  per-slot commitment.
- seed_o  out  8*1920  per-slot seed list.
- masked_key_o  out  8*128  per-slot masked key.
- msgs_o  out  8*512  per-slot broadcast messages.
- C_o  out  8*256  per-slot commitment C.
- seed_lambda_o  out  8*512  per-slot seed_lambda.
- aux_triangle_o  out  8*1024  per-slot aux_triangle.
- parse_end  out  1  done flag.
- parse_err  out  1  malformed lc detected; valid while parse_end=1.

Behaviour:
- Reset: all outputs 0, state IDLE, j=0, counters 0.
- Z field split, MSB first: seed(1920), masked_key(128), msgs(512), C(256), seed_lambda(512), aux_triangle(1024).
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On an edge with parse_start=1 and parse_end=0: register sigma and lc internally.
  - Clear all per-slot outputs and lc_mask_o; set j=0, cnt_u=0 (unchallenged), cnt_c=0 (challenged).
  - Load h_t_o, salt_o, seed_triangle_o; go to SCAN.
- SCAN: one slot per edge, j = 0..7.
  - Slot j is challenged when j equals any of LC0..LC3; entries >7 never match.
  - Challenged and cnt_c<4: write Z[cnt_c] fields into slot j of seed/masked_key/msgs/C/seed_lambda/aux_triangle; set lc_mask_o[j]; cnt_c++.
  - Unchallenged and cnt_u<4: seed_star_o slot j = iSeed[cnt_u]; Cv_o slot j = cv[cnt_u]; cnt_u++.
  - Unused fields of every slot remain 0.
  - If the relevant counter is already 4: write nothing and set the sticky err flag.
  - After processing j=7: go to DONE.
- DONE:
  - parse_end=1.
  - parse_err = err OR (cnt_c != 4); duplicate or out-of-range lc entries therefore flag an error.
  - Outputs hold.
- Latency: start sampled at edge E0; slots processed at E1..E8; parse_end high from E9.
- parse_end stays high while parse_start=1.
- The first edge with parse_start=0 clears parse_end and parse_err and returns to IDLE.
- Outputs keep the last parse result until the next start.
- parse_start dropping during SCAN is ignored: the scan completes and parse_end is high for exactly one cycle.
- sigma and lc changes after E0 have no effect (captured copy).
- Asynchronous reset mid-SCAN or mid-DONE: immediate return to the reset state; no partial parse_end.

Test Plan:
- lc={0,2,4,6}, sigma fields set to distinct patterns (iSeed k = 128'hA0+k, cv k = 256'hC0+k, Z k all bytes = 8'h10+k).
  -> Slots 1,3,5,7 carry seed_star A0..A3 and Cv C0..C3.
  -> Slots 0,2,4,6 carry Z0..Z3 fields.
  -> lc_mask_o=8'h55; parse_end high at E9; parse_err=0.
- lc={7,5,1,3} (unsorted).
  -> Slots 1,3,5,7 get Z0..Z3 in ascending slot order; lc_mask_o=8'hAA; parse_err=0.
- lc={2,2,4,6} (duplicate).
  -> Only 3 challenged slots; the fifth unchallenged slot (j=7) is left 0; parse_err=1 with parse_end.
- lc={0,1,2,9} (out of range).
  -> lc_mask_o=8'h07; parse_err=1.
- Assert reset at E4 of a scan.
  -> All outputs 0 immediately; a fresh start then yields a correct parse with parse_end at E9.
- Hold parse_start high for 20 cycles.
  -> parse_end stays high with no re-parse; drop start -> parse_end=0 next edge; re-assert -> new parse completes.
